// File: rtl/knn_distance_accum_if.sv
// knn_distance_accum_if: stream, query-load and status signals of the distance stage
interface knn_distance_accum_if #(
  parameter int ELEM_WIDTH = 16,
  parameter int VAL_WIDTH  = 32
);
  logic                         clear;
  logic                         query_wr;
  logic signed [ELEM_WIDTH-1:0] queryIn;
  logic                         wr_en;
  logic signed [ELEM_WIDTH-1:0] trainIn;
  logic                         done_in;
  logic                         valid;
  logic [VAL_WIDTH-1:0]         dataValueOut;
  logic                         done;
  logic                         busy;
  logic                         err;
  modport slave (
    input  clear, query_wr, queryIn, wr_en, trainIn, done_in,
    output valid, dataValueOut, done, busy, err
  );
  modport master (
    output clear, query_wr, queryIn, wr_en, trainIn, done_in,
    input  valid, dataValueOut, done, busy, err
  );
endinterface

// File: rtl/knn_distance_accum.sv
// knn_distance_accum: squared Euclidean distance of streamed training vectors to a stored query
module knn_distance_accum #(
  parameter int ELEM_WIDTH = 16,
  parameter int DIMENSIONS = 32,
  parameter int VAL_WIDTH  = 32
) (
  input logic                clk,
  input logic                reset,
  knn_distance_accum_if.slave bus
);
  localparam int AW = DIMENSIONS > 1 ? $clog2(DIMENSIONS) : 1;
  localparam int SW = 2 * ELEM_WIDTH + 2;
  localparam int CW = SW + $clog2(DIMENSIONS);
  localparam logic [AW-1:0] LAST = AW'(DIMENSIONS - 1);

  logic signed [ELEM_WIDTH-1:0] r_query [DIMENSIONS];
  logic [AW-1:0]                r_qaddr;
  logic [AW-1:0]                r_eaddr;
  logic                         r_s0_v, r_s1_v, r_s2_v, r_s3_v;
  logic                         r_s0_first, r_s1_first, r_s2_first;
  logic                         r_s0_last, r_s1_last, r_s2_last, r_s3_last;
  logic signed [ELEM_WIDTH-1:0] r_s0_t, r_s0_q;
  logic signed [ELEM_WIDTH:0]   r_diff;
  logic [SW-1:0]                r_sq;
  logic [CW-1:0]                r_acc;
  logic                         r_valid;
  logic [VAL_WIDTH-1:0]         r_data;
  logic                         r_done;
  logic                         r_err;
  logic                         r_part;
  logic [AW-1:0]                w_eaddr_nxt;
  logic [AW-1:0]                w_qaddr_nxt;
  logic signed [SW-1:0]         w_sq;
  logic [VAL_WIDTH-1:0]         w_sat;
  logic                         w_occupied;
  logic                         w_drained;
  logic                         w_partial;

  assign w_eaddr_nxt = r_eaddr == LAST ? '0 : r_eaddr + 1'b1;
  assign w_qaddr_nxt = r_qaddr == LAST ? '0 : r_qaddr + 1'b1;
  assign w_sq        = SW'(r_diff) * SW'(r_diff);
  assign w_sat       = (r_acc >> VAL_WIDTH) != '0 ? '1 : VAL_WIDTH'(r_acc);
  assign w_occupied  = r_s0_v | r_s1_v | r_s2_v | r_s3_v | r_valid;
  assign w_partial   = bus.done_in && r_eaddr != '0;
  assign w_drained   = bus.done_in && r_eaddr == '0 && !r_part && !w_occupied;

  assign bus.valid        = r_valid;
  assign bus.dataValueOut = r_data;
  assign bus.done         = r_done;
  assign bus.busy         = (r_eaddr != '0) | w_occupied;
  assign bus.err          = r_err;

  // query RAM: written only when no training beat competes for the cycle
  always_ff @(posedge clk)
    if (bus.query_wr && !bus.wr_en) r_query[r_qaddr] <= bus.queryIn;

  // control: element/query counters, stage valids, done and error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_qaddr <= '0;
      r_eaddr <= '0;
      r_s0_v  <= 1'b0;
      r_s1_v  <= 1'b0;
      r_s2_v  <= 1'b0;
      r_s3_v  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_part  <= 1'b0;
    end else if (bus.clear) begin
      r_qaddr <= '0;
      r_eaddr <= '0;
      r_s0_v  <= 1'b0;
      r_s1_v  <= 1'b0;
      r_s2_v  <= 1'b0;
      r_s3_v  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_part  <= 1'b0;
    end else begin
      if (bus.wr_en) r_eaddr <= w_eaddr_nxt;
      if (bus.query_wr && !bus.wr_en) r_qaddr <= w_qaddr_nxt;
      r_s0_v  <= bus.wr_en;
      r_s1_v  <= r_s0_v;
      r_s2_v  <= r_s1_v;
      r_s3_v  <= r_s2_v;
      r_valid <= r_s3_v && r_s3_last;
      r_err   <= r_err | (bus.query_wr && bus.wr_en) | w_partial;
      r_part  <= r_part | w_partial;
      r_done  <= !bus.wr_en && (r_done | w_drained);
    end
  end

  // datapath: sample, difference, square, accumulate, saturate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s0_first <= 1'b0;
      r_s0_last  <= 1'b0;
      r_s0_t     <= '0;
      r_s0_q     <= '0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_diff     <= '0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_sq       <= '0;
      r_s3_last  <= 1'b0;
      r_acc      <= '0;
      r_data     <= '0;
    end else begin
      r_s0_first <= r_eaddr == '0;
      r_s0_last  <= r_eaddr == LAST;
      r_s0_t     <= bus.trainIn;
      r_s0_q     <= r_query[r_eaddr];
      r_s1_first <= r_s0_first;
      r_s1_last  <= r_s0_last;
      r_diff     <= (ELEM_WIDTH+1)'(r_s0_t) - (ELEM_WIDTH+1)'(r_s0_q);
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      r_sq       <= $unsigned(w_sq);
      r_s3_last  <= r_s2_last;
      if (r_s2_v) r_acc <= r_s2_first ? CW'(r_sq) : r_acc + CW'(r_sq);
      if (!bus.clear && r_s3_v && r_s3_last) r_data <= w_sat;
    end
  end
endmodule
